// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - request/response and memory control signals of the memory bus master
interface mem_bus_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 3
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_last;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_en;
    logic              mem_read_en;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_len,
        output req_ready, resp_valid, resp_rdata, resp_last, done,
        output mem_addr, mem_write_en, mem_read_en
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_len,
        input  req_ready, resp_valid, resp_rdata, resp_last, done,
        input  mem_addr, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-word writes and pipelined read bursts to a synchronous single-port memory
module mem_bus_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_master_if.master  bus,
    inout  wire  [DATA_W-1:0] mem_data
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_FILL, RD_STREAM} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              drive_q, drive_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rv_q, rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        re_d    = re_q;
        drive_d = drive_q;
        wdata_d = wdata_q;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        last_d  = 1'b0;
        done_d  = 1'b0;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        drive_d = 1'b1;
                        wdata_d = bus.req_wdata;
                    end else begin
                        state_d = RD_FILL;
                        re_d    = 1'b1;
                        rem_d   = bus.req_len;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                we_d    = 1'b0;
                drive_d = 1'b0;
                done_d  = 1'b1;
            end
            RD_FILL: begin
                state_d = RD_STREAM;
                // the address runs one word ahead of the bus, except on the final beat
                if (rem_q != '0) addr_d = addr_q + ADDR_W'(1);
            end
            RD_STREAM: begin
                rv_d    = 1'b1;
                rdata_d = mem_data;
                if (rem_q == '0) begin
                    last_d  = 1'b1;
                    done_d  = 1'b1;
                    re_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q != LEN_W'(1)) addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            drive_q <= 1'b0;
            wdata_q <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            re_q    <= re_d;
            drive_q <= drive_d;
            wdata_q <= wdata_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    assign mem_data         = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign bus.req_ready    = (state_q == IDLE) & ~rst;
    assign bus.resp_valid   = rv_q;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_last    = last_q;
    assign bus.done         = done_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_write_en = we_q;
    assign bus.mem_read_en  = re_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master with a synchronous memory model
module tb_mem_bus_master;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int LW = 3;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
    wire [DW-1:0] mem_data;

    mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_data (mem_data)
    );

    // synchronous single-port memory: registered read, drives the bus the cycle after read_en
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] mem_rd_q = '0;
    logic          mem_oe_q = 1'b0;
    assign mem_data = mem_oe_q ? mem_rd_q : {DW{1'bz}};
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_addr] <= mem_data;
        if (bus.mem_read_en)  mem_rd_q <= mem[bus.mem_addr];
        mem_oe_q <= bus.mem_read_en;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle expected outputs, filled in when a request is accepted
    bit          exp_we   [MAXC];
    bit          exp_re   [MAXC];
    bit [AW-1:0] exp_addr [MAXC];
    bit [DW-1:0] exp_wd   [MAXC];
    bit          exp_rv   [MAXC];
    bit [DW-1:0] exp_rd   [MAXC];
    bit          exp_last [MAXC];
    bit          exp_done [MAXC];
    bit [DW-1:0] ref_mem  [1<<AW];
    int          busy_end = 0;
    bit          exp_ready;
    int          blen;
    bit [AW-1:0] ta;

    logic [DW-1:0] got_q [$];
    int            rcyc_q [$];
    logic [AW-1:0] addr_q [$];

    initial begin
        forever begin
            @(negedge clk);
            exp_ready = (cyc > busy_end) && !rst;
            if (cyc >= 1 && cyc < MAXC - 20) begin
                chk("req_ready", bus.req_ready, exp_ready);
                chk("mem_write_en", bus.mem_write_en, exp_we[cyc]);
                chk("mem_read_en", bus.mem_read_en, exp_re[cyc]);
                chk("resp_valid", bus.resp_valid, exp_rv[cyc]);
                chk("resp_last", bus.resp_last, exp_last[cyc]);
                chk("done", bus.done, exp_done[cyc]);
                chk("en_exclusive", bus.mem_write_en & bus.mem_read_en, 0);
                chk("bus_contention", mem_oe_q & bus.mem_write_en, 0);
                if (exp_we[cyc] || exp_re[cyc]) chk("mem_addr", bus.mem_addr, exp_addr[cyc]);
                if (exp_we[cyc]) chk("bus_wdata", mem_data, exp_wd[cyc]);
                if (exp_rv[cyc]) chk("resp_rdata", bus.resp_rdata, exp_rd[cyc]);
            end
            if (bus.resp_valid) begin
                got_q.push_back(bus.resp_rdata);
                rcyc_q.push_back(cyc);
            end
            if (bus.mem_read_en) addr_q.push_back(bus.mem_addr);
            if (exp_ready && bus.req_valid && cyc < MAXC - 20) begin
                if (bus.req_write) begin
                    exp_we[cyc+1]   = 1'b1;
                    exp_addr[cyc+1] = bus.req_addr;
                    exp_wd[cyc+1]   = bus.req_wdata;
                    exp_done[cyc+2] = 1'b1;
                    ref_mem[bus.req_addr] = bus.req_wdata;
                    busy_end = cyc + 1;
                end else begin
                    blen = int'(bus.req_len) + 1;
                    exp_re[cyc+1]   = 1'b1;
                    exp_addr[cyc+1] = bus.req_addr;
                    for (int j = 0; j < blen; j++) begin
                        exp_re[cyc+2+j]   = 1'b1;
                        ta = bus.req_addr + AW'((j < blen - 1) ? j + 1 : blen - 1);
                        exp_addr[cyc+2+j] = ta;
                        ta = bus.req_addr + AW'(j);
                        exp_rv[cyc+3+j]   = 1'b1;
                        exp_rd[cyc+3+j]   = ref_mem[ta];
                        exp_last[cyc+3+j] = (j == blen - 1);
                        exp_done[cyc+3+j] = (j == blen - 1);
                    end
                    busy_end = cyc + 1 + blen;
                end
            end
            if (rst && cyc < MAXC - 20) begin
                for (int c = cyc + 1; c < cyc + 20; c++) begin
                    exp_we[c] = 1'b0; exp_re[c] = 1'b0; exp_rv[c] = 1'b0;
                    exp_last[c] = 1'b0; exp_done[c] = 1'b0;
                end
                busy_end = cyc;
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [LW-1:0] len, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = cyc;
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic settle();
        bus.req_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        rcyc_q.delete();
        addr_q.delete();
    endtask

    int acc_r, acc_w, acc_x;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_len   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_resp_rdata", bus.resp_rdata, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // write then single-word read-back
        issue(1'b1, 10'h005, 16'hBEEF, 3'd0, acc_w);
        bus.req_valid = 1'b0;
        clear_mon();
        issue(1'b0, 10'h005, 16'h0000, 3'd0, acc_r);
        settle();
        chk("rb_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("rb_data", got_q[0], 16'hBEEF);
            chk("rb_latency", rcyc_q[0] - acc_r, 3);
        end

        // preload 0x010..0x017 and burst-read all eight
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, AW'(16 + i), DW'(16'h1000 + i), 3'd0, acc_x);
        end
        bus.req_valid = 1'b0;
        clear_mon();
        issue(1'b0, 10'h010, 16'h0000, 3'd7, acc_r);
        settle();
        chk("burst8_count", got_q.size(), 8);
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("burst8_data", got_q[i], 16'h1000 + i);
            chk("burst8_span", rcyc_q[7] - rcyc_q[0], 7);
        end

        // burst wrapping past the top of the address space
        issue(1'b1, 10'h3FE, 16'hA1A1, 3'd0, acc_x);
        issue(1'b1, 10'h3FF, 16'hB2B2, 3'd0, acc_x);
        issue(1'b1, 10'h000, 16'hC3C3, 3'd0, acc_x);
        issue(1'b1, 10'h001, 16'hD4D4, 3'd0, acc_x);
        bus.req_valid = 1'b0;
        clear_mon();
        issue(1'b0, 10'h3FE, 16'h0000, 3'd3, acc_r);
        settle();
        chk("wrap_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("wrap_d0", got_q[0], 16'hA1A1);
            chk("wrap_d1", got_q[1], 16'hB2B2);
            chk("wrap_d2", got_q[2], 16'hC3C3);
            chk("wrap_d3", got_q[3], 16'hD4D4);
        end
        chk("wrap_addr_count", addr_q.size(), 5);
        if (addr_q.size() >= 4) begin
            chk("wrap_a0", addr_q[0], 10'h3FE);
            chk("wrap_a1", addr_q[1], 10'h3FF);
            chk("wrap_a2", addr_q[2], 10'h000);
            chk("wrap_a3", addr_q[3], 10'h001);
        end

        // read followed by a write accepted in the resp_last cycle, then read-back
        issue(1'b1, 10'h020, 16'h1111, 3'd0, acc_x);
        issue(1'b0, 10'h010, 16'h0000, 3'd3, acc_r);
        issue(1'b1, 10'h020, 16'h5A5A, 3'd0, acc_w);
        chk("b2b_accept_gap", acc_w - acc_r, 6);
        bus.req_valid = 1'b0;
        clear_mon();
        issue(1'b0, 10'h020, 16'h0000, 3'd0, acc_r);
        settle();
        chk("b2b_readback_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("b2b_readback", got_q[0], 16'h5A5A);

        // reset on beat 2 of an eight-word burst
        clear_mon();
        issue(1'b0, 10'h010, 16'h0000, 3'd7, acc_r);
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready", bus.req_ready, 0);
        chk("rst_hold_resp_valid", bus.resp_valid, 0);
        chk("rst_hold_read_en", bus.mem_read_en, 0);
        chk("rst_hold_rdata", bus.resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", bus.req_ready, 1);
        settle();
        chk("rst_words_before_abort", got_q.size(), 2);

        // req_valid held high across several requests
        clear_mon();
        issue(1'b1, 10'h030, 16'h7777, 3'd0, acc_x);
        issue(1'b1, 10'h031, 16'h8888, 3'd0, acc_x);
        issue(1'b0, 10'h030, 16'h0000, 3'd1, acc_x);
        issue(1'b1, 10'h032, 16'h9999, 3'd0, acc_x);
        settle();
        chk("cont_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("cont_d0", got_q[0], 16'h7777);
            chk("cont_d1", got_q[1], 16'h8888);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
